// File: rtl/register_file_8x16_pkg.sv
//------------------------------------------------------------------------------
// register_file_8x16_pkg : shared widths, counts and address type
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package register_file_8x16_pkg;

    localparam int REG_ADDR_W         = 3;
    localparam int REG_COUNT          = 8;
    localparam int REG_WIDTH_DEFAULT  = 16;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/register_file_8x16_if.sv
//------------------------------------------------------------------------------
// register_file_8x16_if : write port and both read ports of the register file
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface register_file_8x16_if
    import register_file_8x16_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEFAULT
);
    logic             WriteEnable;
    reg_addr_t        WriteAddr;
    logic [WIDTH-1:0] WriteData;
    logic             ReadEnableA;
    reg_addr_t        ReadAddrA;
    logic [WIDTH-1:0] ReadDataA;
    logic             ReadEnableB;
    reg_addr_t        ReadAddrB;
    logic [WIDTH-1:0] ReadDataB;

    modport master (
        output WriteEnable, WriteAddr, WriteData,
        output ReadEnableA, ReadAddrA, ReadEnableB, ReadAddrB,
        input  ReadDataA, ReadDataB
    );

    modport slave (
        input  WriteEnable, WriteAddr, WriteData,
        input  ReadEnableA, ReadAddrA, ReadEnableB, ReadAddrB,
        output ReadDataA, ReadDataB
    );
endinterface

`default_nettype wire

// File: rtl/register_file_8x16_read_port_mux16.sv
//------------------------------------------------------------------------------
// read_port_mux16 : WIDTH-wide 8:1 read selector built from per-bit mux cells
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module eight_to_one_mux (
    input  wire logic [7:0] I_i,
    input  wire logic       S2_i,
    input  wire logic       S1_i,
    input  wire logic       S0_i,
    input  wire logic       Enable_i,
    output logic            Y_o
);
    assign Y_o = Enable_i & I_i[{S2_i, S1_i, S0_i}];
endmodule

module read_port_mux16
    import register_file_8x16_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEFAULT
)(
    input  wire logic [REG_COUNT-1:1][WIDTH-1:0] regs_i,
    input  wire reg_addr_t                      addr_i,
    input  wire logic                           enable_i,
    output logic [WIDTH-1:0]                    data_o
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [7:0] w_bit_in;

        // Slot 0 is R0, which is never stored and always selects zero.
        assign w_bit_in[0] = 1'b0;
        for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
            assign w_bit_in[r] = regs_i[r][b];
        end

        eight_to_one_mux u_mux (
            .I_i      (w_bit_in),
            .S2_i     (addr_i[2]),
            .S1_i     (addr_i[1]),
            .S0_i     (addr_i[0]),
            .Enable_i (enable_i),
            .Y_o      (data_o[b])
        );
    end
endmodule

`default_nettype wire

// File: rtl/register_file_8x16.sv
//------------------------------------------------------------------------------
// register_file_8x16 : 8x16 register file, R0 hardwired to zero, 1W/2R, optional bypass
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module register_file_8x16
    import register_file_8x16_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH_DEFAULT,
    parameter bit BYPASS = 1'b1
)(
    input  wire logic           Clk,
    input  wire logic           Reset,
    register_file_8x16_if.slave bus
);
    logic [REG_COUNT-1:1][WIDTH-1:0] regs_q;
    logic [REG_COUNT-1:1][WIDTH-1:0] regs_d;
    logic [WIDTH-1:0]                w_mux_a;
    logic [WIDTH-1:0]                w_mux_b;
    logic                            w_en_a;
    logic                            w_en_b;

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (bus.WriteEnable && (bus.WriteAddr == reg_addr_t'(i))) begin
                regs_d[i] = bus.WriteData;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads are forced to zero for the whole reset interval, bypass included.
    assign w_en_a = bus.ReadEnableA & ~Reset;
    assign w_en_b = bus.ReadEnableB & ~Reset;

    read_port_mux16 #(.WIDTH(WIDTH)) u_port_a (
        .regs_i   (regs_q),
        .addr_i   (bus.ReadAddrA),
        .enable_i (w_en_a),
        .data_o   (w_mux_a)
    );

    read_port_mux16 #(.WIDTH(WIDTH)) u_port_b (
        .regs_i   (regs_q),
        .addr_i   (bus.ReadAddrB),
        .enable_i (w_en_b),
        .data_o   (w_mux_b)
    );

    if (BYPASS) begin : g_bypass
        logic w_hit_a;
        logic w_hit_b;

        assign w_hit_a = w_en_a && bus.WriteEnable && (bus.ReadAddrA == bus.WriteAddr)
                         && (bus.ReadAddrA != REG_ZERO);
        assign w_hit_b = w_en_b && bus.WriteEnable && (bus.ReadAddrB == bus.WriteAddr)
                         && (bus.ReadAddrB != REG_ZERO);

        assign bus.ReadDataA = w_hit_a ? bus.WriteData : w_mux_a;
        assign bus.ReadDataB = w_hit_b ? bus.WriteData : w_mux_b;
    end else begin : g_no_bypass
        assign bus.ReadDataA = w_mux_a;
        assign bus.ReadDataB = w_mux_b;
    end
endmodule

`default_nettype wire

// File: tb/tb_register_file_8x16.sv
//------------------------------------------------------------------------------
// tb_register_file_8x16 : scoreboard bench driving BYPASS=1 and BYPASS=0 instances in lockstep
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_file_8x16;
    import register_file_8x16_pkg::*;

    logic        clk;
    logic        rst;
    logic        we;
    reg_addr_t   waddr;
    logic [15:0] wdata;
    logic        rea;
    reg_addr_t   raddra;
    logic        reb;
    reg_addr_t   raddrb;

    int compared = 0;
    int failed   = 0;

    string       name_q[$];
    int          dut_q[$];
    int          port_q[$];
    logic [15:0] val_q[$];

    register_file_8x16_if #(.WIDTH(16)) if1 ();
    register_file_8x16_if #(.WIDTH(16)) if0 ();

    assign if1.WriteEnable = we;     assign if0.WriteEnable = we;
    assign if1.WriteAddr   = waddr;  assign if0.WriteAddr   = waddr;
    assign if1.WriteData   = wdata;  assign if0.WriteData   = wdata;
    assign if1.ReadEnableA = rea;    assign if0.ReadEnableA = rea;
    assign if1.ReadAddrA   = raddra; assign if0.ReadAddrA   = raddra;
    assign if1.ReadEnableB = reb;    assign if0.ReadEnableB = reb;
    assign if1.ReadAddrB   = raddrb; assign if0.ReadAddrB   = raddrb;

    register_file_8x16 #(.WIDTH(16), .BYPASS(1'b1)) u_dut_byp (
        .Clk   (clk),
        .Reset (rst),
        .bus   (if1)
    );

    register_file_8x16 #(.WIDTH(16), .BYPASS(1'b0)) u_dut_nobyp (
        .Clk   (clk),
        .Reset (rst),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string n, input int d, input int p, input logic [15:0] v);
        name_q.push_back(n);
        dut_q.push_back(d);
        port_q.push_back(p);
        val_q.push_back(v);
    endtask

    // Same expectation on both ports of both instances.
    task automatic push_all(input string n, input logic [15:0] a, input logic [15:0] b);
        push(n, 1, 0, a);
        push(n, 1, 1, b);
        push(n, 0, 0, a);
        push(n, 0, 1, b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        while (val_q.size() > 0) begin
            string       n;
            int          d;
            int          p;
            logic [15:0] v;
            logic [15:0] act;
            n = name_q.pop_front();
            d = dut_q.pop_front();
            p = port_q.pop_front();
            v = val_q.pop_front();
            if (d == 1) act = (p == 0) ? if1.ReadDataA : if1.ReadDataB;
            else        act = (p == 0) ? if0.ReadDataA : if0.ReadDataB;
            compared++;
            if (act !== v) begin
                failed++;
                $display("FAIL %s (bypass=%0d port=%s): got %h expected %h",
                         n, d, (p == 0) ? "A" : "B", act, v);
            end
        end
    end

    logic [15:0] exp_regs [8];

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        rea = 1'b1; raddra = 3'd5; reb = 1'b1; raddrb = 3'd2;
        step();
        push_all("in_reset", 16'h0000, 16'h0000);
        step();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            raddra = reg_addr_t'(i);
            raddrb = reg_addr_t'(7 - i);
            push_all("after_reset", 16'h0000, 16'h0000);
            step();
        end

        raddra = 3'd0; raddrb = 3'd0;
        we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
        step();
        waddr = 3'd7; wdata = 16'h1234;
        step();
        we = 1'b0; raddra = 3'd3; raddrb = 3'd7;
        push_all("wr_rd_r3_r7", 16'hBEEF, 16'h1234);
        step();

        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddra = 3'd0; raddrb = 3'd0;
        push_all("r0_during_write", 16'h0000, 16'h0000);
        step();
        we = 1'b0;
        exp_regs = '{16'h0000, 16'h0000, 16'h0000, 16'hBEEF,
                     16'h0000, 16'h0000, 16'h0000, 16'h1234};
        for (int i = 0; i < 8; i++) begin
            raddra = reg_addr_t'(i);
            raddrb = reg_addr_t'(i);
            push_all("r0_protect", exp_regs[i], exp_regs[i]);
            step();
        end

        we = 1'b1; waddr = 3'd5; wdata = 16'h00A5;
        step();
        we = 1'b0; raddra = 3'd5; raddrb = 3'd3;
        push_all("rden_on", 16'h00A5, 16'hBEEF);
        step();
        rea = 1'b0; reb = 1'b0;
        push_all("rden_off", 16'h0000, 16'h0000);
        step();
        rea = 1'b1; reb = 1'b1;

        we = 1'b1; waddr = 3'd2; wdata = 16'h1111;
        step();
        wdata = 16'h2222; raddra = 3'd2; raddrb = 3'd2;
        push("bypass_before_edge", 1, 0, 16'h2222);
        push("bypass_before_edge", 1, 1, 16'h2222);
        push("bypass_before_edge", 0, 0, 16'h1111);
        push("bypass_before_edge", 0, 1, 16'h1111);
        step();
        we = 1'b0;
        push_all("bypass_after_edge", 16'h2222, 16'h2222);
        step();

        we = 1'b1; waddr = 3'd4; wdata = 16'hCAFE;
        step();
        wdata = 16'h5555; raddra = 3'd4; raddrb = 3'd3;
        #2;
        rst = 1'b1;
        push_all("async_reset_mid", 16'h0000, 16'h0000);
        step();
        rst = 1'b0; we = 1'b0;
        push_all("after_async_reset", 16'h0000, 16'h0000);
        step();

        we = 1'b1; waddr = 3'd1; wdata = 16'h0F0F; raddra = 3'd1; raddrb = 3'd4;
        step();
        we = 1'b0;
        push_all("first_write_post_reset", 16'h0F0F, 16'h0000);
        step();

        @(negedge clk);
        #1;
        if (val_q.size() != 0) begin
            compared++;
            failed++;
            $display("FAIL drain: got %0d pending expected 0", val_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/register_file_8x16.md
# register_file_8x16

Eight-entry, 16-bit general-purpose register file for the 16-bit RISC-V datapath, sitting directly upstream of the per-bit 8:1 read multiplexers. The block supplies the operand registers those multiplexers select from. It provides one synchronous write port and two combinational read ports, A and B. Register R0 is hardwired to zero. An optional write-to-read bypass lets a decode stage see the value being written in the same cycle.

## Interface
- WIDTH, 16, data width of each register and of each port.
- BYPASS, 1, 1 = a read of the register being written returns the write data in the same cycle; 0 = it returns the stored (old) value.

- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears R1..R7 to 0 immediately.
- WriteEnable  in  1  commits WriteData to register WriteAddr at the rising edge of Clk.
- WriteAddr  in  3  destination register index.
- WriteData  in  WIDTH  value to store.
- ReadEnableA  in  1  gates port A; when low, ReadDataA = 0.
- ReadAddrA  in  3  port A register index.
- ReadDataA  out  WIDTH  port A data, combinational.
- ReadEnableB  in  1  gates port B; when low, ReadDataB = 0.
- ReadAddrB  in  3  port B register index.
- ReadDataB  out  WIDTH  port B data, combinational.

## Operation
- Storage: R1..R7, each WIDTH bits. R0 is not stored and always reads 0.
- Write:
  - When WriteEnable = 1 and WriteAddr != 0, R[WriteAddr] <= WriteData at the rising edge of Clk.
  - WriteAddr = 0 is silently discarded.
  - WriteEnable = 0 leaves all registers unchanged.
- Read, per port, combinational:
  - Data = 0 if ReadEnable = 0.
  - Otherwise data = 0 if the address is 0.
  - Otherwise, with BYPASS = 1, WriteEnable = 1 and address == WriteAddr, data = WriteData.
  - Otherwise data = R[address].
- Ports A and B are fully independent. Both may address the same register, and both are then bypassed identically.
- Reset:
  - R1..R7 clear asynchronously on the assertion of Reset, not waiting for a clock edge.
  - While Reset is high, writes are ignored and reads return 0 for every address.
  - The bypass is also suppressed while Reset is high.
- Reset asserted mid-cycle while WriteEnable is high: the write is lost and the register reads 0 after reset.
- No X propagation: every output is a defined 0 or a register value at all times after the first Reset.

## Timing
- Write latency: 1 cycle. Data presented before edge N is readable from the stored value after edge N.
- Read latency: 0 cycles, purely combinational from the address, enable and register state.
- With BYPASS = 1, the read-after-write distance is effectively 0 cycles for the same-cycle write.
- Reset: outputs are 0 within combinational delay of Reset rising.
- Deassertion of Reset takes effect for the next rising edge of Clk. The first write may occur on the first edge with Reset low.
- Simultaneous write and read of the same register:
  - BYPASS = 0: the old value is visible until the edge, the new value after it.
  - BYPASS = 1: the new value is visible throughout.

## Structure
- Shared package:
  - REG_ADDR_W = 3
  - REG_COUNT = 8
  - REG_ZERO = 3'd0
  - the WIDTH default
  - a reg_addr_t typedef
- Sub-module: read_port_mux16, instantiated twice (ports A and B).
  - A WIDTH-wide 8:1 selector built from eight_to_one_mux cells, one per bit.
  - Select is {S2,S1,S0} = address and Enable = ReadEnable.
  - Input I0 is tied to 0.
- Bypass compare and override sit in the top level, after the mux.

## Test plan
- Reset and read-back:
  - Stimulus: Reset pulse, then read all 8 addresses on both ports with enables high.
  - Required response: every read returns 0x0000.
- Write then read, distinct ports:
  - Stimulus: write R3 = 0xBEEF and R7 = 0x1234 on consecutive edges; then ReadAddrA = 3, ReadAddrB = 7.
  - Required response: A = 0xBEEF, B = 0x1234.
- R0 protection:
  - Stimulus: write R0 = 0xFFFF.
  - Required response: reading address 0 on both ports returns 0x0000, and R1..R7 are unchanged.
- Read enable gating:
  - Stimulus: R5 = 0x00A5, ReadAddrA = 5, ReadEnableA toggled 1 -> 0.
  - Required response: A = 0x00A5, then A = 0x0000.
- Bypass, with BYPASS = 1:
  - Stimulus: R2 = 0x1111; in the same cycle set WriteData = 0x2222, WriteAddr = 2, ReadAddrA = 2.
  - Required response: A = 0x2222 before the edge.
  - Rerun with BYPASS = 0: A = 0x1111 before the edge and 0x2222 after it.
- Asynchronous reset mid-operation:
  - Stimulus: R4 = 0xCAFE; assert Reset between clock edges while WriteEnable = 1 with WriteData = 0x5555 to R4.
  - Required response: A (addr 4) drops to 0x0000 before the next edge and stays 0x0000 after Reset is released.
